// File: rtl/fxp_dot_engine_if.sv
// rtl/fxp_dot_engine_if.sv - job control, input beat and result stream bundle for fxp_dot_engine
interface fxp_dot_engine_if #(
   parameter int DATA_W = 16,
   parameter int LANES  = 4,
   parameter int MAX_K  = 256
);
   localparam int LEN_W = $clog2(MAX_K + 1);

   logic                    start;
   logic [LEN_W-1:0]        cfg_len;
   logic                    busy;
   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*DATA_W-1:0] in_a;
   logic [LANES*DATA_W-1:0] in_b;
   logic                    out_valid;
   logic                    out_ready;
   logic [DATA_W-1:0]       out_data;
   logic                    out_sat;

   modport master (
      output start, cfg_len, in_valid, in_a, in_b, out_ready,
      input  busy, in_ready, out_valid, out_data, out_sat
   );

   modport slave (
      input  start, cfg_len, in_valid, in_a, in_b, out_ready,
      output busy, in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/fxp_dot_engine.sv
// rtl/fxp_dot_engine.sv - signed fixed-point dot-product engine; FXP_SAT_EN enables output clamping
module fxp_dot_engine #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8,
   parameter int LANES  = 4,
   parameter int ACC_W  = 32,
   parameter int MAX_K  = 256
) (
   input logic               clk,
   input logic               rst_n,
   fxp_dot_engine_if.slave   bus
);
   localparam int LEN_W = $clog2(MAX_K + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

   state_t                   state, state_nx;
   logic [LEN_W-1:0]         len_q;
   logic [LEN_W-1:0]         cnt_q;
   logic signed [2*DATA_W-1:0] full_prod [LANES];
   logic signed [ACC_W-1:0]  prod_nx [LANES];
   logic signed [ACC_W-1:0]  prod_q [LANES];
   logic                     s1_valid;
   logic                     s2_valid;
   logic signed [ACC_W-1:0]  lane_sum;
   logic signed [ACC_W-1:0]  acc_q;
   logic [DATA_W-1:0]        res_data;
   logic                     res_sat;
   logic [DATA_W-1:0]        out_data_q;
   logic                     out_sat_q;
   logic                     job_start;
   logic                     take_beat;
   logic                     last_beat;

   assign job_start = (state == IDLE) && bus.start;
   assign take_beat = (state == ACCUM) && bus.in_valid;
   assign last_beat = take_beat && ((cnt_q + LEN_W'(1)) == len_q);

   assign bus.busy      = (state != IDLE);
   assign bus.in_ready  = (state == ACCUM);
   assign bus.out_valid = (state == OUT);
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;

   // State register; reset aborts any job in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state: zero-length jobs skip straight to OUT; DRAIN waits for the pipeline to empty.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_nx = (bus.cfg_len == '0) ? OUT : ACCUM;
            end
         end
         ACCUM: begin
            if (last_beat) begin
               state_nx = DRAIN;
            end
         end
         DRAIN: begin
            if (!s1_valid && !s2_valid) begin
               state_nx = OUT;
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Job length latch and beat counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_q <= '0;
         cnt_q <= '0;
      end else if (job_start) begin
         len_q <= bus.cfg_len;
         cnt_q <= '0;
      end else if (take_beat) begin
         cnt_q <= cnt_q + LEN_W'(1);
      end
   end

   // Per-lane product, floored to the binary point and resized to the accumulator width.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         full_prod[i] = $signed(bus.in_a[i*DATA_W +: DATA_W]) * $signed(bus.in_b[i*DATA_W +: DATA_W]);
         prod_nx[i]   = ACC_W'(full_prod[i] >>> FRAC_W);
      end
   end

   // S1: register lane products; valid bits track which stages hold live data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            prod_q[i] <= '0;
         end
      end else begin
         s1_valid <= take_beat;
         s2_valid <= s1_valid;
         if (take_beat) begin
            for (int i = 0; i < LANES; i++) begin
               prod_q[i] <= prod_nx[i];
            end
         end
      end
   end

   // Adder tree over the registered lane products.
   always_comb begin
      lane_sum = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_sum = lane_sum + prod_q[i];
      end
   end

   // S2: accumulate, wrapping modulo 2^ACC_W; cleared at the start of each job.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else if (job_start) begin
         acc_q <= '0;
      end else if (s1_valid) begin
         acc_q <= acc_q + lane_sum;
      end
   end

`ifdef FXP_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   // Clamp the final accumulator into the representable output range.
   always_comb begin
      res_data = acc_q[DATA_W-1:0];
      res_sat  = 1'b0;
      if (acc_q > SAT_MAX) begin
         res_data = SAT_MAX[DATA_W-1:0];
         res_sat  = 1'b1;
      end else if (acc_q < SAT_MIN) begin
         res_data = SAT_MIN[DATA_W-1:0];
         res_sat  = 1'b1;
      end
   end
`else
   // Plain truncation: low DATA_W bits equal wrap-around accumulation at output width.
   always_comb begin
      res_data = acc_q[DATA_W-1:0];
      res_sat  = 1'b0;
   end
`endif

   // Result register: loaded on entry to OUT and held stable until consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
      end else if (job_start && (bus.cfg_len == '0)) begin
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
      end else if ((state == DRAIN) && (state_nx == OUT)) begin
         out_data_q <= res_data;
         out_sat_q  <= res_sat;
      end
   end
endmodule

// File: tb/tb_fxp_dot_engine.sv
// tb/tb_fxp_dot_engine.sv - directed self-checking bench for fxp_dot_engine
module tb_fxp_dot_engine;
   localparam int DATA_W = 16;
   localparam int FRAC_W = 8;
   localparam int LANES  = 4;
   localparam int ACC_W  = 32;
   localparam int MAX_K  = 256;

   logic clk;
   logic rst_n;
   int   n_assert;
   int   n_fail;

   fxp_dot_engine_if #(.DATA_W(DATA_W), .LANES(LANES), .MAX_K(MAX_K)) bus ();

   fxp_dot_engine #(
      .DATA_W(DATA_W), .FRAC_W(FRAC_W), .LANES(LANES), .ACC_W(ACC_W), .MAX_K(MAX_K)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input int len);
      if (len > MAX_K) begin
         $display("FAIL cfg_len_range: observed %0d expected <= %0d", len, MAX_K);
         $fatal(1, "cfg_len out of range");
      end
      bus.start   = 1'b1;
      bus.cfg_len = len[8:0];
      @(negedge clk);
      bus.start   = 1'b0;
   endtask

   task automatic send_beat(input logic [63:0] a, input logic [63:0] b);
      int waitc;
      waitc = 0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_b     = b;
      while (!bus.in_ready && waitc < 20) begin
         @(negedge clk);
         waitc++;
      end
      if (waitc >= 20) check("beat_ready_timeout", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_result(output int cyc);
      cyc = 0;
      while (!bus.out_valid && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("post_hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("post_hs_busy", {31'd0, bus.busy}, 32'd0);
   endtask

   function automatic logic signed [31:0] model_prod(input logic [15:0] a, input logic [15:0] b);
      logic signed [31:0] p;
      p = $signed(a) * $signed(b);
      return p >>> FRAC_W;
   endfunction

   function automatic logic [16:0] model_narrow(input logic signed [31:0] acc);
`ifdef FXP_SAT_EN
      if (acc > 32'sd32767) return {1'b1, 16'h7FFF};
      if (acc < -32'sd32768) return {1'b1, 16'h8000};
`endif
      return {1'b0, acc[15:0]};
   endfunction

   logic [63:0] fa [6];
   logic [63:0] fb [6];
   logic signed [31:0] macc;
   logic [16:0] mres;
   int cyc;

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.cfg_len = '0; bus.in_valid = 1'b0;
      bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b0;
      fa = '{64'h0180_FE00_0100_7FFF, 64'h0040_0040_FFC0_0300, 64'h1000_F000_0001_8000,
             64'h00FF_0101_FF01_0010, 64'h0200_0200_0200_0200, 64'hFFFF_0002_8000_0123};
      fb = '{64'h0100_0080_FF00_0001, 64'h0400_FC00_0100_0100, 64'h0010_0010_7FFF_0001,
             64'h0101_FF00_0100_0020, 64'hFE00_0100_0080_0001, 64'h0003_FFFF_8000_0456};

      // reset state
      repeat (2) @(negedge clk);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_sat", {31'd0, bus.out_sat}, 32'd0);
      check("rst_out_data", {16'd0, bus.out_data}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // in_valid in IDLE is ignored
      bus.in_valid = 1'b1; bus.in_a = {4{16'h0100}}; bus.in_b = {4{16'h0100}};
      @(negedge clk);
      check("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("idle_busy", {31'd0, bus.busy}, 32'd0);
      bus.in_valid = 1'b0;

      // basic: 2 beats of 1.0*0.5 on 4 lanes -> 4.0
      start_job(2);
      check("basic_busy", {31'd0, bus.busy}, 32'd1);
      send_beat({4{16'h0100}}, {4{16'h0080}});
      send_beat({4{16'h0100}}, {4{16'h0080}});
      wait_result(cyc);
      check("basic_latency", cyc, 32'd3);
      check("basic_data", {16'd0, bus.out_data}, 32'h0400);
      check("basic_sat", {31'd0, bus.out_sat}, 32'd0);
      check("basic_in_ready_out", {31'd0, bus.in_ready}, 32'd0);
      consume();

      // negative: -1.0*0.5 per lane -> -2.0
      start_job(1);
      send_beat({4{16'hFF00}}, {4{16'h0080}});
      wait_result(cyc);
      check("neg_latency", cyc, 32'd3);
      check("neg_data", {16'd0, bus.out_data}, 32'hFE00);
      consume();

      // floor truncation: -1/256 * 1/256 floors to -1 lsb per lane
      start_job(1);
      send_beat({4{16'hFFFF}}, {4{16'h0001}});
      wait_result(cyc);
      check("floor_data", {16'd0, bus.out_data}, 32'hFFFC);
      consume();

      // overflow: 127.0*127.0 per lane
      start_job(1);
      send_beat({4{16'h7F00}}, {4{16'h7F00}});
      wait_result(cyc);
`ifdef FXP_SAT_EN
      check("ovf_data", {16'd0, bus.out_data}, 32'h7FFF);
      check("ovf_sat", {31'd0, bus.out_sat}, 32'd1);
`else
      check("ovf_data", {16'd0, bus.out_data}, 32'h0400);
      check("ovf_sat", {31'd0, bus.out_sat}, 32'd0);
`endif
      consume();

      // flow control: bubbles, stray start pulse, stalled output, junk beats after ACCUM
      macc = '0;
      for (int j = 0; j < 6; j++) begin
         for (int l = 0; l < LANES; l++) begin
            macc = macc + model_prod(fa[j][l*16 +: 16], fb[j][l*16 +: 16]);
         end
      end
      mres = model_narrow(macc);
      start_job(6);
      for (int j = 0; j < 6; j++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         if (j == 2) begin
            bus.start = 1'b1; bus.cfg_len = 9'd1;
            @(negedge clk);
            bus.start = 1'b0;
         end
         send_beat(fa[j], fb[j]);
      end
      bus.in_valid = 1'b1; bus.in_a = {4{16'h1234}}; bus.in_b = {4{16'h4321}};
      bus.start = 1'b1; bus.cfg_len = 9'd3;
      wait_result(cyc);
      bus.start = 1'b0;
      check("flow_latency", cyc, 32'd3);
      check("flow_in_ready_out", {31'd0, bus.in_ready}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("flow_stall_valid%0d", k), {31'd0, bus.out_valid}, 32'd1);
         check($sformatf("flow_stall_data%0d", k), {16'd0, bus.out_data}, {16'd0, mres[15:0]});
         check($sformatf("flow_stall_sat%0d", k), {31'd0, bus.out_sat}, {31'd0, mres[16]});
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      consume();
      @(negedge clk);
      check("flow_idle_after", {31'd0, bus.busy}, 32'd0);

      // zero-length job: result 0 on the very next cycle
      start_job(0);
      check("zero_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("zero_data", {16'd0, bus.out_data}, 32'h0);
      check("zero_sat", {31'd0, bus.out_sat}, 32'd0);
      consume();

      // leave a nonzero result in the output register, then reset mid-ACCUM
      start_job(1);
      send_beat({4{16'h0100}}, {4{16'h0100}});
      wait_result(cyc);
      check("pre_rst_data", {16'd0, bus.out_data}, 32'h0400);
      consume();
      start_job(4);
      send_beat({4{16'h0100}}, {4{16'h0100}});
      rst_n = 1'b0;
      #1;
      check("midrst_busy", {31'd0, bus.busy}, 32'd0);
      check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst_out_data", {16'd0, bus.out_data}, 32'h0);
      check("midrst_out_sat", {31'd0, bus.out_sat}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // job after reset: 2.0*3.0 on 4 lanes -> 24.0
      start_job(1);
      send_beat({4{16'h0200}}, {4{16'h0300}});
      wait_result(cyc);
      check("post_rst_latency", cyc, 32'd3);
      check("post_rst_data", {16'd0, bus.out_data}, 32'h1800);
      consume();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
